// File: rtl/sram_responder_pkg.sv
// Shared widths and FSM encoding for the SRAM responder.
package sram_responder_pkg;

  localparam int unsigned SRAM_ADDR_W = 16;
  localparam int unsigned SRAM_DATA_W = 32;
  localparam int unsigned CNT_W       = 32;

  // Host port handshake state
  typedef enum logic {
    RESP_STATE_IDLE = 1'b0,
    RESP_STATE_ACK  = 1'b1
  } resp_state_e;

endpackage

// File: rtl/sram_responder_sram_core.sv
// Single-port synchronous RAM with a registered read port.
// Ports:
//   clk      - clock
//   en       - access enable
//   we       - write (1) / read (0), qualified by en
//   addr     - word address
//   wr_data  - write data
//   rd_data  - read data, loaded on a read and held otherwise
module sram_responder_sram_core
  import sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is intentionally unreset; contents survive reset
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wr_data;
      end else begin
        rd_data <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder: serves CPU SRAM accesses with priority and a host
// load/dump port with a req/ack handshake; counts CPU reads and writes.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   sram_ADDR/DI/EN/WE   - CPU access request
//   sram_DO              - CPU read data, held until the next CPU read
//   host_req/we/addr/wdata - host access request (level)
//   host_ack             - one-cycle completion pulse
//   host_rdata           - host read data, held after the ack
//   rd_cnt, wr_cnt       - wrapping CPU read/write counters
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sram_ADDR,
  input  logic [DATA_W-1:0] sram_DI,
  input  logic              sram_EN,
  input  logic              sram_WE,
  output logic [DATA_W-1:0] sram_DO,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  resp_state_e       state;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              host_go;
  logic              core_en;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;

  // Which requester owns the data in core_rdata this cycle
  logic              cpu_sel;
  logic              host_sel;
  logic [DATA_W-1:0] do_hold;
  logic [DATA_W-1:0] rdata_hold;

  // Port arbitration: CPU wins; host only proceeds from IDLE on an EN-free cycle
  assign cpu_rd  = !reset && sram_EN && !sram_WE;
  assign cpu_wr  = !reset && sram_EN && sram_WE;
  assign host_go = !reset && (state == RESP_STATE_IDLE) && host_req && !sram_EN;

  assign core_en    = cpu_rd || cpu_wr || host_go;
  assign core_we    = sram_EN ? sram_WE   : host_we;
  assign core_addr  = sram_EN ? sram_ADDR : host_addr;
  assign core_wdata = sram_EN ? sram_DI   : host_wdata;

  sram_responder_sram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clk     (clk),
    .en      (core_en),
    .we      (core_we),
    .addr    (core_addr),
    .wr_data (core_wdata),
    .rd_data (core_rdata)
  );

  // The shared read register is exposed to its owner for the cycle after the
  // read, then captured into a per-requester hold register.
  assign sram_DO    = cpu_sel  ? core_rdata : do_hold;
  assign host_rdata = host_sel ? core_rdata : rdata_hold;

  // Handshake FSM, hold registers and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RESP_STATE_IDLE;
      host_ack   <= 1'b0;
      cpu_sel    <= 1'b0;
      host_sel   <= 1'b0;
      do_hold    <= '0;
      rdata_hold <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
    end else begin
      cpu_sel  <= cpu_rd;
      host_sel <= host_go && !host_we;
      if (cpu_sel) begin
        do_hold <= core_rdata;
      end
      if (host_sel) begin
        rdata_hold <= core_rdata;
      end
      if (cpu_rd) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (cpu_wr) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end

      case (state)
        RESP_STATE_IDLE: begin
          host_ack <= 1'b0;
          if (host_go) begin
            state    <= RESP_STATE_ACK;
            host_ack <= 1'b1;
          end
        end
        RESP_STATE_ACK: begin
          state    <= RESP_STATE_IDLE;
          host_ack <= 1'b0;
        end
        default: begin
          state    <= RESP_STATE_IDLE;
          host_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios plus randomized
// CPU/host traffic against a word-level memory model.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sram_ADDR;
  logic [31:0] sram_DI;
  logic        sram_EN;
  logic        sram_WE;
  logic [31:0] sram_DO;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [31:0] mem_m [logic [15:0]];
  logic [31:0] exp_do;
  logic [31:0] exp_rd;
  logic [31:0] exp_wr;

  sram_responder dut (
    .clk        (clk),
    .reset      (reset),
    .sram_ADDR  (sram_ADDR),
    .sram_DI    (sram_DI),
    .sram_EN    (sram_EN),
    .sram_WE    (sram_WE),
    .sram_DO    (sram_DO),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU cycle; model updated after the edge
  task automatic cpu_op(input logic en, input logic we, input logic [15:0] a, input logic [31:0] d);
    sram_EN   = en;
    sram_WE   = we;
    sram_ADDR = a;
    sram_DI   = d;
    tick();
    if (en && we) begin
      mem_m[a] = d;
      exp_wr   = exp_wr + 32'd1;
    end else if (en) begin
      exp_do = mem_m[a];
      exp_rd = exp_rd + 32'd1;
    end
  endtask

  task automatic check_cpu(input string name);
    checks++;
    if (sram_DO !== exp_do || rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
      failures++;
      $display("FAIL %s: sram_DO=%h rd_cnt=%0d wr_cnt=%0d, required sram_DO=%h rd_cnt=%0d wr_cnt=%0d",
               name, sram_DO, rd_cnt, wr_cnt, exp_do, exp_rd, exp_wr);
    end
  endtask

  // Host access with CPU idle; returns cycles until ack becomes visible
  task automatic host_xfer(input logic we, input logic [15:0] a, input logic [31:0] d, output int lat);
    bit done = 0;
    sram_EN    = 1'b0;
    sram_WE    = 1'b0;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (host_ack === 1'b1) done = 1;
    end
    host_req = 1'b0;
    if (done && we) mem_m[a] = d;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL host_xfer_timeout: no host_ack within 20 cycles for addr %h", a);
    end else if (!we && host_rdata !== mem_m[a]) begin
      failures++;
      $display("FAIL host_read_data: host_rdata=%h required %h @%h", host_rdata, mem_m[a], a);
    end
    tick();
    checks++;
    if (host_ack !== 1'b0) begin
      failures++;
      $display("FAIL host_ack_pulse: host_ack=%b one cycle after ack, required 0", host_ack);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    exp_do = 32'h0;
    exp_rd = 32'h0;
    exp_wr = 32'h0;
  endtask

  task automatic test_reset();
    sram_EN = 0; sram_WE = 0; sram_ADDR = 0; sram_DI = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    do_reset();
    check_cpu("reset_values");
    checks++;
    if (host_ack !== 1'b0 || host_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_host: host_ack=%b host_rdata=%h, required 0/0", host_ack, host_rdata);
    end
  endtask

  task automatic test_host_rw();
    int lat;
    host_xfer(1'b1, 16'h0010, 32'h1234ABCD, lat);
    checks++;
    if (lat != 1) begin
      failures++;
      $display("FAIL host_write_latency: ack after %0d cycles, required 1", lat);
    end
    host_xfer(1'b0, 16'h0010, 32'h0, lat);
    checks++;
    if (lat != 1 || host_rdata !== 32'h1234ABCD) begin
      failures++;
      $display("FAIL host_read_0010: lat=%0d rdata=%h, required 1 / 1234abcd", lat, host_rdata);
    end
    check_cpu("host_leaves_cpu_state");
  endtask

  task automatic test_cpu_wr_rd();
    cpu_op(1, 1, 16'd5, 32'hDEADBEEF);
    check_cpu("cpu_write_5");
    cpu_op(1, 0, 16'd5, 32'h0);
    check_cpu("cpu_read_5");
    checks++;
    if (sram_DO !== 32'hDEADBEEF || wr_cnt !== 32'd1 || rd_cnt !== 32'd1) begin
      failures++;
      $display("FAIL cpu_wr_rd_const: DO=%h wr=%0d rd=%0d, required deadbeef/1/1", sram_DO, wr_cnt, rd_cnt);
    end
  endtask

  task automatic test_hold();
    cpu_op(1, 0, 16'd5, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cpu_op(0, 0, 16'd5, 32'h0);
      check_cpu("do_hold_idle");
    end
    cpu_op(1, 1, 16'd5, 32'h0);
    check_cpu("no_write_through");
    checks++;
    if (sram_DO !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL no_write_through_const: DO=%h required deadbeef", sram_DO);
    end
  endtask

  task automatic test_host_stall();
    cpu_op(1, 1, 16'd5, 32'hCAFEF00D);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 16'd5;
    for (int i = 0; i < 4; i++) begin
      cpu_op(1, 0, 16'd5, 32'h0);
      checks++;
      if (host_ack !== 1'b0) begin
        failures++;
        $display("FAIL stall_no_ack: host_ack=%b during CPU cycle %0d, required 0", host_ack, i);
      end
    end
    cpu_op(0, 0, 16'd0, 32'h0);
    host_req = 1'b0;
    checks++;
    if (host_ack !== 1'b1 || host_rdata !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL stall_ack: ack=%b rdata=%h, required 1/cafef00d", host_ack, host_rdata);
    end
    cpu_op(0, 0, 16'd0, 32'h0);
    check_cpu("after_stall");
  endtask

  task automatic test_en_off();
    int lat;
    host_xfer(1'b1, 16'd7, 32'h00000777, lat);
    cpu_op(0, 1, 16'd7, 32'hFFFFFFFF);
    check_cpu("en0_write_ignored_cnt");
    cpu_op(1, 0, 16'd7, 32'h0);
    checks++;
    if (sram_DO !== 32'h00000777) begin
      failures++;
      $display("FAIL en0_write_ignored_mem: mem[7]=%h required 00000777", sram_DO);
    end
  endtask

  task automatic test_reset_in_ack();
    sram_EN    = 0;
    host_req   = 1;
    host_we    = 1;
    host_addr  = 16'h0020;
    host_wdata = 32'hA5A50006;
    tick();
    mem_m[16'h0020] = 32'hA5A50006;
    checks++;
    if (host_ack !== 1'b1) begin
      failures++;
      $display("FAIL reset_ack_setup: host_ack=%b required 1", host_ack);
    end
    host_req = 0;
    reset    = 1;
    tick();
    checks++;
    if (host_ack !== 1'b0 || sram_DO !== 32'h0 || rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin
      failures++;
      $display("FAIL reset_in_ack: ack=%b DO=%h rd=%0d wr=%0d, required 0/0/0/0", host_ack, sram_DO, rd_cnt, wr_cnt);
    end
    reset  = 0;
    exp_do = 0; exp_rd = 0; exp_wr = 0;
    cpu_op(1, 0, 16'h0020, 32'h0);
    check_cpu("reset_keeps_host_write");
    cpu_op(1, 0, 16'd5, 32'h0);
    check_cpu("reset_keeps_mem5");
  endtask

  task automatic test_random();
    int          lat;
    bit          pending  = 0;
    bit          cooldown = 0;
    int          waitc    = 0;
    logic        h_we;
    logic [15:0] h_a;
    logic [31:0] h_d;
    logic [31:0] last_h = 32'h0;
    bit          have_h = 0;
    logic        en, we;
    logic [15:0] a;
    logic [31:0] d;
    for (int k = 0; k < 16; k++) host_xfer(1'b1, 16'h0100 + 16'(k), $urandom, lat);
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) < 6);
      we = $urandom_range(0, 1) == 1;
      a  = 16'h0100 + 16'($urandom_range(0, 15));
      d  = $urandom;
      if (!pending && !cooldown && $urandom_range(0, 3) == 0) begin
        h_we = $urandom_range(0, 1) == 1;
        h_a  = 16'h0100 + 16'($urandom_range(0, 15));
        h_d  = $urandom;
        host_req = 1; host_we = h_we; host_addr = h_a; host_wdata = h_d;
        pending = 1; waitc = 0;
      end
      cooldown = 0;
      sram_EN = en; sram_WE = we; sram_ADDR = a; sram_DI = d;
      tick();
      // Host side resolves against memory as of the access edge
      if (pending) begin
        waitc++;
        if (host_ack === 1'b1) begin
          pending  = 0;
          cooldown = 1;
          host_req = 0;
          if (h_we) mem_m[h_a] = h_d;
          else begin
            checks++;
            if (host_rdata !== mem_m[h_a]) begin
              failures++;
              $display("FAIL rand_host_read: rdata=%h required %h @%h", host_rdata, mem_m[h_a], h_a);
            end
            last_h = mem_m[h_a];
            have_h = 1;
          end
        end else if (waitc > 60) begin
          checks++;
          failures++;
          $display("FAIL rand_host_timeout: no ack after %0d cycles", waitc);
          pending = 0;
          host_req = 0;
        end
      end else begin
        checks++;
        if (host_ack !== 1'b0 || (have_h && host_rdata !== last_h)) begin
          failures++;
          $display("FAIL rand_host_idle: ack=%b rdata=%h, required 0/%h", host_ack, host_rdata, last_h);
        end
      end
      if (en && we) begin
        mem_m[a] = d;
        exp_wr   = exp_wr + 32'd1;
      end else if (en) begin
        exp_do = mem_m[a];
        exp_rd = exp_rd + 32'd1;
      end
      check_cpu("rand_cpu");
    end
    host_req = 0;
    sram_EN  = 0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_host_rw();
    test_cpu_wr_rd();
    test_hold();
    test_host_stall();
    test_en_off();
    test_reset_in_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
